// File: rtl/wb_arbiter.sv
// Two-requester register-file writeback arbiter with round-robin priority and a
// busy-register scoreboard that stalls decode on reserved long-latency destinations.
module wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        b_ready,
  input  logic        issue_en,
  input  logic [4:0]  issue_addr,
  input  logic [4:0]  rd_addr1,
  input  logic [4:0]  rd_addr2,
  output logic        stall,
  output logic        wen,
  output logic [4:0]  r3,
  output logic [31:0] WD,
  output logic [31:0] busy
);

  // prefer_b_q set means B wins a tie; A was the most recent grant.
  logic        prefer_b_q, prefer_b_d;
  logic        wen_q, wen_d;
  logic [4:0]  r3_q, r3_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] busy_q, busy_d;

  logic        accept_a, accept_b;
  logic [4:0]  win_addr;
  logic [31:0] win_data;

  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!rst) begin
      a_ready = a_valid && (!b_valid || !prefer_b_q);
      b_ready = b_valid && (!a_valid ||  prefer_b_q);
    end
  end

  assign accept_a = a_valid && a_ready;
  assign accept_b = b_valid && b_ready;
  assign win_addr = accept_b ? b_addr : a_addr;
  assign win_data = accept_b ? b_data : a_data;

  always_comb begin
    prefer_b_d = prefer_b_q;
    if (accept_a) begin
      prefer_b_d = 1'b1;
    end else if (accept_b) begin
      prefer_b_d = 1'b0;
    end
  end

  // Writes to r0 complete the handshake but leave the write port untouched.
  always_comb begin
    wen_d = 1'b0;
    r3_d  = r3_q;
    wd_d  = wd_q;
    if ((accept_a || accept_b) && (win_addr != 5'd0)) begin
      wen_d = 1'b1;
      r3_d  = win_addr;
      wd_d  = win_data;
    end
  end

  // Clear first so a same-edge issue to the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (accept_b && (b_addr != 5'd0)) begin
      busy_d[b_addr] = 1'b0;
    end
    if (issue_en && (issue_addr != 5'd0)) begin
      busy_d[issue_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prefer_b_q <= 1'b0;
      wen_q      <= 1'b0;
      r3_q       <= 5'd0;
      wd_q       <= 32'd0;
      busy_q     <= 32'd0;
    end else begin
      prefer_b_q <= prefer_b_d;
      wen_q      <= wen_d;
      r3_q       <= r3_d;
      wd_q       <= wd_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    stall = ((rd_addr1 != 5'd0) && busy_q[rd_addr1]) ||
            ((rd_addr2 != 5'd0) && busy_q[rd_addr2]);
  end

  assign wen  = wen_q;
  assign r3   = r3_q;
  assign WD   = wd_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed vector table plus hand-written contention and mid-transfer reset sequences.
module tb_wb_arbiter;

  logic        clk, rst;
  logic        a_valid, b_valid, issue_en;
  logic [4:0]  a_addr, b_addr, issue_addr, rd_addr1, rd_addr2;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, stall, wen;
  logic [4:0]  r3;
  logic [31:0] WD, busy;

  int errors = 0;
  int checks = 0;

  wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .a_valid    (a_valid),
    .a_addr     (a_addr),
    .a_data     (a_data),
    .a_ready    (a_ready),
    .b_valid    (b_valid),
    .b_addr     (b_addr),
    .b_data     (b_data),
    .b_ready    (b_ready),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .rd_addr1   (rd_addr1),
    .rd_addr2   (rd_addr2),
    .stall      (stall),
    .wen        (wen),
    .r3         (r3),
    .WD         (WD),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic        ie;
    logic [4:0]  ia;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        e_ar;
    logic        e_br;
    logic        e_st;
    logic        e_wen;
    logic [4:0]  e_r3;
    logic [31:0] e_wd;
    logic [31:0] e_busy;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                              input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                              input logic ie, input logic [4:0] ia,
                              input logic [4:0] r1, input logic [4:0] r2,
                              input logic e_ar, input logic e_br, input logic e_st,
                              input logic e_wen, input logic [4:0] e_r3,
                              input logic [31:0] e_wd, input logic [31:0] e_busy);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
    v.ie = ie; v.ia = ia; v.r1 = r1; v.r2 = r2;
    v.e_ar = e_ar; v.e_br = e_br; v.e_st = e_st; v.e_wen = e_wen;
    v.e_r3 = e_r3; v.e_wd = e_wd; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    a_valid = 0; a_addr = 0; a_data = 0;
    b_valid = 0; b_addr = 0; b_data = 0;
    issue_en = 0; issue_addr = 0; rd_addr1 = 0; rd_addr2 = 0;
  endtask

  // Outputs expected in the cycle the vector is driven: readies/stall for its inputs,
  // wen/r3/WD/busy as left by the previous edge.
  task automatic fill();
    //            av aa  ad       bv ba bd       ie ia r1 r2  ar br st wen r3 wd       busy
    vecs[0]  = mk(1, 5, 32'h1234, 0, 0, 0,       0, 0, 0, 0,  1, 0, 0, 0, 0, 0,       0);
    vecs[1]  = mk(0, 0, 0,        0, 0, 0,       0, 0, 0, 0,  0, 0, 0, 1, 5, 32'h1234, 0);
    vecs[2]  = mk(0, 0, 0,        0, 0, 0,       0, 0, 0, 0,  0, 0, 0, 0, 5, 32'h1234, 0);
    vecs[3]  = mk(1, 1, 32'h11,   1, 2, 32'h22,  0, 0, 0, 0,  0, 1, 0, 0, 5, 32'h1234, 0);
    vecs[4]  = mk(1, 1, 32'h11,   1, 3, 32'h33,  0, 0, 0, 0,  1, 0, 0, 1, 2, 32'h22,   0);
    vecs[5]  = mk(0, 0, 0,        1, 3, 32'h33,  0, 0, 0, 0,  0, 1, 0, 1, 1, 32'h11,   0);
    vecs[6]  = mk(0, 0, 0,        0, 0, 0,       1, 7, 7, 0,  0, 0, 0, 1, 3, 32'h33,   0);
    vecs[7]  = mk(0, 0, 0,        0, 0, 0,       0, 0, 7, 0,  0, 0, 1, 0, 3, 32'h33,   32'h80);
    vecs[8]  = mk(0, 0, 0,        1, 7, 32'h77,  0, 0, 7, 0,  0, 1, 1, 0, 3, 32'h33,   32'h80);
    vecs[9]  = mk(0, 0, 0,        0, 0, 0,       0, 0, 7, 0,  0, 0, 0, 1, 7, 32'h77,   0);
    vecs[10] = mk(0, 0, 0,        0, 0, 0,       1, 9, 0, 9,  0, 0, 0, 0, 7, 32'h77,   0);
    vecs[11] = mk(0, 0, 0,        1, 9, 32'h99,  1, 9, 0, 9,  0, 1, 1, 0, 7, 32'h77,   32'h200);
    vecs[12] = mk(0, 0, 0,        0, 0, 0,       0, 0, 0, 9,  0, 0, 1, 1, 9, 32'h99,   32'h200);
    vecs[13] = mk(1, 0, 32'hdead, 0, 0, 0,       1, 0, 0, 0,  1, 0, 0, 0, 9, 32'h99,   32'h200);
    vecs[14] = mk(0, 0, 0,        0, 0, 0,       0, 0, 0, 0,  0, 0, 0, 0, 9, 32'h99,   32'h200);
    vecs[15] = mk(0, 0, 0,        1, 0, 32'h1,   0, 0, 0, 0,  0, 1, 0, 0, 9, 32'h99,   32'h200);
    vecs[16] = mk(1, 9, 32'haa,   0, 0, 0,       0, 0, 0, 9,  1, 0, 1, 0, 9, 32'h99,   32'h200);
    vecs[17] = mk(0, 0, 0,        1, 9, 32'h5,   0, 0, 0, 9,  0, 1, 1, 1, 9, 32'haa,   32'h200);
    vecs[18] = mk(0, 0, 0,        0, 0, 0,       0, 0, 0, 9,  0, 0, 0, 1, 9, 32'h5,    0);
    vecs[19] = mk(0, 0, 0,        0, 0, 0,       0, 0, 0, 0,  0, 0, 0, 0, 9, 32'h5,    0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [4:0] exp_r3;

  initial begin
    rst = 1'b1;
    idle();
    a_valid = 1; a_addr = 3; b_valid = 1; b_addr = 4;
    #2;
    // Reset state, with requests pending, before any clock edge.
    chk("rst_a_ready", {31'd0, a_ready}, 0);
    chk("rst_b_ready", {31'd0, b_ready}, 0);
    chk("rst_wen", {31'd0, wen}, 0);
    chk("rst_r3", {27'd0, r3}, 0);
    chk("rst_wd", WD, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stall", {31'd0, stall}, 0);
    do_reset();

    fill();
    for (int i = 0; i < 20; i++) begin
      a_valid = vecs[i].av; a_addr = vecs[i].aa; a_data = vecs[i].ad;
      b_valid = vecs[i].bv; b_addr = vecs[i].ba; b_data = vecs[i].bd;
      issue_en = vecs[i].ie; issue_addr = vecs[i].ia;
      rd_addr1 = vecs[i].r1; rd_addr2 = vecs[i].r2;
      @(negedge clk);
      chk($sformatf("v%0d_a_ready", i), {31'd0, a_ready}, {31'd0, vecs[i].e_ar});
      chk($sformatf("v%0d_b_ready", i), {31'd0, b_ready}, {31'd0, vecs[i].e_br});
      chk($sformatf("v%0d_stall", i), {31'd0, stall}, {31'd0, vecs[i].e_st});
      chk($sformatf("v%0d_wen", i), {31'd0, wen}, {31'd0, vecs[i].e_wen});
      chk($sformatf("v%0d_r3", i), {27'd0, r3}, {27'd0, vecs[i].e_r3});
      chk($sformatf("v%0d_wd", i), WD, vecs[i].e_wd);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
      @(posedge clk);
      #1;
    end

    // Contention straight after reset: grants alternate A,B,A,B starting with A.
    do_reset();
    a_valid = 1; a_addr = 1; a_data = 32'h100;
    b_valid = 1; b_addr = 2; b_data = 32'h200;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) begin
        a_valid = 0; b_valid = 0;
      end
      @(negedge clk);
      if (k < 4) begin
        chk($sformatf("cont%0d_a_ready", k), {31'd0, a_ready}, {31'd0, (k % 2) == 0});
        chk($sformatf("cont%0d_b_ready", k), {31'd0, b_ready}, {31'd0, (k % 2) == 1});
      end
      chk($sformatf("cont%0d_wen", k), {31'd0, wen}, {31'd0, (k >= 1) && (k <= 4)});
      if (k >= 1 && k <= 4) begin
        exp_r3 = ((k % 2) == 1) ? 5'd1 : 5'd2;
        chk($sformatf("cont%0d_r3", k), {27'd0, r3}, {27'd0, exp_r3});
        chk($sformatf("cont%0d_wd", k), WD, (exp_r3 == 5'd1) ? 32'h100 : 32'h200);
      end
      @(posedge clk);
      #1;
    end

    // Asynchronous reset between an accept edge and the following edge.
    idle();
    a_valid = 1; a_addr = 6; a_data = 32'h66;
    issue_en = 1; issue_addr = 4;
    @(negedge clk);
    chk("mid_a_ready", {31'd0, a_ready}, 1);
    @(posedge clk);
    #1 idle();
    rd_addr1 = 4;
    #1;
    chk("mid_pre_wen", {31'd0, wen}, 1);
    chk("mid_pre_busy", busy, 32'h10);
    chk("mid_pre_stall", {31'd0, stall}, 1);
    a_valid = 1; a_addr = 8; b_valid = 1; b_addr = 8;
    rst = 1'b1;
    #1;
    chk("mid_rst_wen", {31'd0, wen}, 0);
    chk("mid_rst_r3", {27'd0, r3}, 0);
    chk("mid_rst_wd", WD, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_stall", {31'd0, stall}, 0);
    chk("mid_rst_a_ready", {31'd0, a_ready}, 0);
    chk("mid_rst_b_ready", {31'd0, b_ready}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d_wen", k), {31'd0, wen}, 0);
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
